// File: rtl/nor_bus_pkg.sv
`default_nettype none
// nor_bus_pkg: shared widths, state encoding and requester index for the NOR arbiter.
package nor_bus_pkg;

  localparam int NOR_AW = 26;
  localparam int NOR_DW = 16;

  typedef logic req_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RYWAIT = 3'd4,
    ST_DONE   = 3'd5
  } nor_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nor_ry_sync.sv
`default_nettype none
// nor_ry_sync: 2-flop RY/BY synchroniser plus saturating wait/timeout counter.
module nor_ry_sync
  import nor_bus_pkg::*;
#(
  parameter int RY_TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ry_async,
  output logic ready,
  output logic timeout
);

  localparam int TW         = $clog2(RY_TIMEOUT + 1);
  localparam int ARM_CYCLES = 4;

  logic          ry_meta;
  logic          ry_sync;
  logic          seen_low;
  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ry_meta  <= 1'b1;
      ry_sync  <= 1'b1;
      seen_low <= 1'b0;
      cnt      <= '0;
    end else begin
      ry_meta <= ry_async;
      ry_sync <= ry_meta;
      if (!en) begin
        cnt      <= '0;
        seen_low <= 1'b0;
      end else begin
        if (cnt != TW'(RY_TIMEOUT)) cnt <= cnt + 1'b1;
        if (!ry_sync) seen_low <= 1'b1;
      end
    end
  end

  // The device may take a few cycles to pull RY/BY low, so a high level only
  // counts as "ready" once it has been seen low or the arming window expired.
  assign ready   = en && ry_sync && (seen_low || (cnt >= TW'(ARM_CYCLES)));
  assign timeout = en && (cnt >= TW'(RY_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/nor_bus_arb.sv
`default_nettype none
// nor_bus_arb: two-requester round-robin arbiter driving an asynchronous NOR flash bus.
// Optional RY/BY write wait is enabled by defining NOR_ARB_RYBY_WAIT_EN.
module nor_bus_arb
  import nor_bus_pkg::*;
#(
  parameter int T_SETUP    = 2,
  parameter int T_PULSE    = 4,
  parameter int T_HOLD     = 2,
  parameter int RY_TIMEOUT = 65535
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [NOR_AW-1:0] addr0_i,
  input  logic [NOR_AW-1:0] addr1_i,
  input  logic [NOR_DW-1:0] wdata0_i,
  input  logic [NOR_DW-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic [NOR_DW-1:0] rdata_o,
  output logic [1:0]        gnt_o,
  output logic              busy_o,
  output logic [NOR_AW-1:0] nor_addr_o,
  output logic [NOR_DW-1:0] nor_data_o,
  output logic              nor_data_oe,
  output logic              nor_ce_o,
  output logic              nor_oe_o,
  output logic              nor_we_o,
  input  logic [NOR_DW-1:0] nor_data_i,
  input  logic              nor_ry_i,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(max3(T_SETUP, T_PULSE, T_HOLD) + 1);

  nor_state_e       state;
  logic [CNT_W-1:0] cnt;
  req_idx_t         prio;
  req_idx_t         owner;
  req_idx_t         winner;
  logic             is_write;

  always_comb begin
    winner = prio;
    if (req_i == 2'b01)      winner = 1'b0;
    else if (req_i == 2'b10) winner = 1'b1;
  end

  assign busy_o = (state != ST_IDLE);

`ifdef NOR_ARB_RYBY_WAIT_EN
  logic ry_ready;
  logic ry_timeout;

  nor_ry_sync #(.RY_TIMEOUT(RY_TIMEOUT)) u_ry_sync (
    .clk      (clk_i),
    .rst_n    (reset_ni),
    .en       (state == ST_RYWAIT),
    .ry_async (nor_ry_i),
    .ready    (ry_ready),
    .timeout  (ry_timeout)
  );
`else
  logic unused_ry;
  assign unused_ry = nor_ry_i ^ (RY_TIMEOUT == 0);
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      prio        <= 1'b0;
      owner       <= 1'b0;
      is_write    <= 1'b0;
      ack_o       <= 2'b00;
      gnt_o       <= 2'b00;
      rdata_o     <= '0;
      nor_addr_o  <= '0;
      nor_data_o  <= '0;
      nor_data_oe <= 1'b0;
      nor_ce_o    <= 1'b1;
      nor_oe_o    <= 1'b1;
      nor_we_o    <= 1'b1;
`ifdef NOR_ARB_RYBY_WAIT_EN
      timeout_o   <= 1'b0;
`endif
    end else begin
      ack_o <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|req_i) begin
            owner       <= winner;
            prio        <= ~winner;
            gnt_o       <= winner ? 2'b10 : 2'b01;
            is_write    <= we_i[winner];
            nor_addr_o  <= winner ? addr1_i : addr0_i;
            nor_data_o  <= winner ? wdata1_i : wdata0_i;
            nor_data_oe <= we_i[winner];
            nor_ce_o    <= 1'b0;
            cnt         <= '0;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CNT_W'(T_SETUP - 1)) begin
            cnt   <= '0;
            state <= ST_PULSE;
            if (is_write) nor_we_o <= 1'b0;
            else          nor_oe_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == CNT_W'(T_PULSE - 1)) begin
            cnt      <= '0;
            state    <= ST_HOLD;
            nor_oe_o <= 1'b1;
            nor_we_o <= 1'b1;
            if (!is_write) rdata_o <= nor_data_i;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == CNT_W'(T_HOLD - 1)) begin
            cnt         <= '0;
            nor_ce_o    <= 1'b1;
            nor_data_oe <= 1'b0;
`ifdef NOR_ARB_RYBY_WAIT_EN
            if (is_write) begin
              state <= ST_RYWAIT;
            end else begin
              state        <= ST_DONE;
              ack_o[owner] <= 1'b1;
            end
`else
            state        <= ST_DONE;
            ack_o[owner] <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef NOR_ARB_RYBY_WAIT_EN
        ST_RYWAIT: begin
          if (ry_ready || ry_timeout) begin
            if (!ry_ready) timeout_o <= 1'b1;
            state        <= ST_DONE;
            ack_o[owner] <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          gnt_o <= 2'b00;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nor_bus_arb.sv
`default_nettype none
// tb_nor_bus_arb: directed stimulus with a phase-timeline reference model of nor_bus_arb.
module tb_nor_bus_arb;

  localparam int T_S = 2;
  localparam int T_P = 4;
  localparam int T_H = 2;
  localparam int RYT = 100;
  localparam int KP  = T_S + T_P;          // last PULSE offset
  localparam int KH  = T_S + T_P + T_H;    // last HOLD offset

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00, we = 2'b00;
  logic [25:0] addr0 = '0, addr1 = '0;
  logic [15:0] wd0 = '0, wd1 = '0, nor_din = '0;
  logic        ry = 1'b1;
  logic [1:0]  ack, gnt;
  logic [15:0] rdata, ndata;
  logic [25:0] naddr;
  logic        busy, ndoe, nce, noe, nwe, tmo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nor_bus_arb #(.T_SETUP(T_S), .T_PULSE(T_P), .T_HOLD(T_H), .RY_TIMEOUT(RYT)) dut (
    .clk_i(clk), .reset_ni(rst_n), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wd0), .wdata1_i(wd1),
    .ack_o(ack), .rdata_o(rdata), .gnt_o(gnt), .busy_o(busy),
    .nor_addr_o(naddr), .nor_data_o(ndata), .nor_data_oe(ndoe),
    .nor_ce_o(nce), .nor_oe_o(noe), .nor_we_o(nwe),
    .nor_data_i(nor_din), .nor_ry_i(ry), .timeout_o(tmo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a timeline of offsets from the IDLE cycle
  // in which its request was sampled; outputs follow from the offset alone.
  logic        m_active = 1'b0;
  logic        m_owner, m_we, m_prio = 1'b0;
  logic [25:0] m_addr;
  logic [15:0] m_wd, m_rd;
  int          m_start, cyc = 0;

  always @(negedge clk) begin : cmp
    int k;
    logic [1:0] oh, e_ack, e_gnt;
    logic in_ce, in_p, done;
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_prio   = 1'b0;
      chk("reset_bus", {nce, noe, nwe, ndoe, gnt, ack, busy}, {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0});
      chk("reset_addr_data", {naddr, ndata, rdata, tmo}, '0);
    end else begin
      if (!m_active && req != 2'b00) begin
        m_owner  = (req == 2'b11) ? m_prio : req[1];
        m_prio   = ~m_owner;
        m_active = 1'b1;
        m_start  = cyc;
        m_we     = we[m_owner];
        m_addr   = m_owner ? addr1 : addr0;
        m_wd     = m_owner ? wd1 : wd0;
      end
      k     = m_active ? cyc - m_start : 0;
      oh    = m_owner ? 2'b10 : 2'b01;
      in_ce = m_active && k >= 1 && k <= KH;
      in_p  = m_active && k > T_S && k <= KP;
      e_gnt = (m_active && k >= 1) ? oh : 2'b00;
      done  = m_active && k == KH + 1;
`ifdef NOR_ARB_RYBY_WAIT_EN
      if (m_active && m_we && k > KH) begin
        done = (ack == oh);
        if (k > KH + RYT + 4) chk("rywait_bound", k, KH + RYT + 1);
      end
`endif
      e_ack = done ? oh : 2'b00;
      chk("cycle_bus", {nce, noe, nwe, ndoe, gnt, ack, busy},
          {~in_ce, ~(in_p & ~m_we), ~(in_p & m_we), in_ce & m_we, e_gnt, e_ack, m_active && k >= 1});
      chk("strobe_rule", {~noe & ~nwe, (~noe | ~nwe) & nce}, 2'b00);
`ifndef NOR_ARB_RYBY_WAIT_EN
      chk("timeout_tied", tmo, 1'b0);
`endif
      if (m_active && k >= 1) chk("nor_addr", naddr, m_addr);
      if (m_active && k >= 1 && m_we) chk("nor_data", ndata, m_wd);
      if (m_active && k == KP && !m_we) m_rd = nor_din;
      if (done && !m_we) chk("read_data", rdata, m_rd);
      if (done) m_active = 1'b0;
    end
  end

  // One request from idle; req dropped once granted. nor_din carries dval only
  // in the last PULSE cycle so the capture point matters.
  task automatic run_txn(input logic [1:0] rq, input logic [1:0] wv, input logic [15:0] dval,
                         output int lat, output int oe_c, output int we_c, output int doe_c,
                         output logic [1:0] ackv, output logic [1:0] gv, output logic [15:0] rd);
    lat = 0; oe_c = 0; we_c = 0; doe_c = 0; ackv = 2'b00; gv = 2'b00; rd = '0;
    @(posedge clk); #2;
    req = rq; we = wv;
    for (int l = 0; l < 300; l++) begin
      if (l > 0) begin
        @(posedge clk); #2;
        if (gv != 2'b00) req = 2'b00;
      end
      nor_din = (l == KP) ? dval : (dval ^ 16'h5A5A);
      @(negedge clk);
      if (!noe) oe_c++;
      if (!nwe) we_c++;
      if (ndoe) doe_c++;
      if (gnt != 2'b00 && gv == 2'b00) gv = gnt;
      if (ack != 2'b00) begin
        lat = l; ackv = ack; rd = rdata;
        break;
      end
      if (l == 299) chk("txn_bound", l, 0);
    end
    @(posedge clk); #2;
    req = 2'b00;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int lat, oe_c, we_c, doe_c, acks, d, rise_l;
    logic [1:0] ackv, gv;
    logic [15:0] rd;
    logic [7:0] seq;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ce_oe_we", {nce, noe, nwe}, 3'b111);
    chk("reset_busy_gnt", {busy, gnt}, 3'b000);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single read, requester 0
    addr0 = 26'h155AAAA; addr1 = 26'h0000123;
    run_txn(2'b01, 2'b00, 16'hBEEF, lat, oe_c, we_c, doe_c, ackv, gv, rd);
    chk("read_latency", lat, 9);
    chk("read_oe_cycles", oe_c, 4);
    chk("read_we_cycles", we_c, 0);
    chk("read_ack", ackv, 2'b01);
    chk("read_rdata", rd, 16'hBEEF);

    // Write, requester 1
    addr1 = 26'h2000040; wd1 = 16'h00F0;
    run_txn(2'b10, 2'b10, 16'h1111, lat, oe_c, we_c, doe_c, ackv, gv, rd);
    chk("write_we_cycles", we_c, 4);
    chk("write_oe_cycles", oe_c, 0);
    chk("write_doe_cycles", doe_c, KH);
    chk("write_ack", ackv, 2'b10);

    // Lone requester 1 wins even though requester 0 now has priority
    addr1 = 26'h3FFFFFF;
    run_txn(2'b10, 2'b00, 16'hA5C3, lat, oe_c, we_c, doe_c, ackv, gv, rd);
    chk("lone_req1_gnt", gv, 2'b10);
    chk("lone_req1_rdata", rd, 16'hA5C3);

    // Both requesting continuously: grants alternate, starting with 0
    addr0 = 26'h0000010; addr1 = 26'h0000020; nor_din = 16'h7E57;
    @(posedge clk); #2;
    req = 2'b11; we = 2'b00;
    seq = '0; acks = 0;
    for (int l = 0; l < 100 && acks < 4; l++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        chk("rr_ack_matches_gnt", ack, gnt);
        seq = {seq[5:0], ack};
        acks++;
      end
    end
    chk("rr_sequence", seq, 8'b01_10_01_10);
    @(posedge clk); #2;
    req = 2'b00;
    repeat (3) @(posedge clk);

    // Reset during PULSE of a read
    #2;
    addr0 = 26'h0ABCDEF; req = 2'b01; we = 2'b00;
    for (int l = 0; l < 20; l++) begin
      @(negedge clk);
      if (!noe) break;
      if (l == 19) chk("reach_pulse_bound", l, 0);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_strobes", {nce, noe, nwe, ndoe}, 4'b1110);
    chk("midreset_gnt_busy_addr", {gnt, busy, naddr}, '0);
    req = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack != 2'b00) acks++;
    end
    chk("no_ack_after_reset", acks, 0);

    // Priority pointer back at requester 0 after reset
    run_txn(2'b11, 2'b00, 16'h0F0F, lat, oe_c, we_c, doe_c, ackv, gv, rd);
    chk("post_reset_prio", gv, 2'b01);
    chk("post_reset_ack", ackv, 2'b01);

`ifdef NOR_ARB_RYBY_WAIT_EN
    // RY/BY rising 50 cycles into the wait
    ry = 1'b0; wd0 = 16'h1234;
    @(posedge clk); #2;
    req = 2'b01; we = 2'b01; rise_l = -1; d = -1;
    for (int l = 0; l < 400; l++) begin
      @(negedge clk);
      if (gnt != 2'b00) req = 2'b00;
      if (ack != 2'b00) begin d = l - rise_l; break; end
      if (l == KH + 50) begin #1; ry = 1'b1; rise_l = l; end
    end
    chk("ry_rise_ack_within_3", (d >= 0 && d <= 3), 1'b1);
    chk("ry_rise_no_timeout", tmo, 1'b0);
    repeat (2) @(posedge clk);

    // RY/BY stuck low: timeout after RY_TIMEOUT wait cycles
    ry = 1'b0;
    run_txn(2'b01, 2'b01, 16'h0000, lat, oe_c, we_c, doe_c, ackv, gv, rd);
    chk("ry_timeout_latency", lat, KH + 1 + RYT);
    chk("ry_timeout_ack", ackv, 2'b01);
    chk("ry_timeout_flag", tmo, 1'b1);
    ry = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
